// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from two requesters to one UART
// transmitter, with launch strobe, done timeout and inter-byte gap.
module uart_tx_arbiter #(
    parameter int DONE_TIMEOUT = 1024,
    parameter int GAP_CLKS     = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Req0_Valid,
    input  logic [7:0] i_Req0_Byte,
    output logic       o_Req0_Ready,
    input  logic       i_Req1_Valid,
    input  logic [7:0] i_Req1_Byte,
    output logic       o_Req1_Ready,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic [1:0] o_Grant,
    output logic       o_Busy,
    output logic       o_Timeout
);

    localparam int TW = 11;
    localparam int GW = 4;
    localparam logic [TW-1:0] TO_LAST  = TW'(DONE_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    generate
        if (DONE_TIMEOUT < 16 || DONE_TIMEOUT > 2047) begin : g_bad_to
            $error("DONE_TIMEOUT out of range 16..2047");
        end
        if (GAP_CLKS < 1 || GAP_CLKS > 15) begin : g_bad_gap
            $error("GAP_CLKS out of range 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          r_State;
    state_t          w_Next;
    logic [TW-1:0]   r_To_Cnt;
    logic [TW-1:0]   w_To_Cnt;
    logic [GW-1:0]   r_Gap_Cnt;
    logic [GW-1:0]   w_Gap_Cnt;
    logic [7:0]      r_Tx_Byte;
    logic [7:0]      w_Tx_Byte;
    logic [1:0]      r_Grant;
    logic [1:0]      w_Grant;
    logic            r_Prio;
    logic            w_Prio;

    logic            w_Win0;
    logic            w_Win1;
    logic            w_Can_Accept;
    logic            w_Rdy0;
    logic            w_Rdy1;
    logic            w_To_Hit;

    // r_Prio = 0 means requester 0 wins a tie, 1 means requester 1
    assign w_Win0 = i_Req0_Valid & (~i_Req1_Valid | ~r_Prio);
    assign w_Win1 = i_Req1_Valid & (~i_Req0_Valid | r_Prio);

    assign w_Can_Accept = (r_State == S_IDLE) & ~i_Tx_Active & ~i_Reset;
    assign w_Rdy0       = w_Can_Accept & w_Win0;
    assign w_Rdy1       = w_Can_Accept & w_Win1;

    // Done in the last timeout cycle takes precedence over the abort
    assign w_To_Hit = (r_State == S_WAIT) & ~i_Tx_Done
                    & (r_To_Cnt == TO_LAST);

    assign o_Req0_Ready = w_Rdy0;
    assign o_Req1_Ready = w_Rdy1;
    assign o_Tx_DV      = (r_State == S_LAUNCH);
    assign o_Tx_Byte    = r_Tx_Byte;
    assign o_Grant      = r_Grant;
    assign o_Busy       = (r_State != S_IDLE);
    assign o_Timeout    = w_To_Hit;

    always_comb begin
        w_Next    = r_State;
        w_To_Cnt  = r_To_Cnt;
        w_Gap_Cnt = r_Gap_Cnt;
        w_Tx_Byte = r_Tx_Byte;
        w_Grant   = r_Grant;
        w_Prio    = r_Prio;
        unique case (r_State)
            S_IDLE: begin
                if (w_Rdy0 | w_Rdy1) begin
                    w_Tx_Byte = w_Rdy1 ? i_Req1_Byte : i_Req0_Byte;
                    w_Grant   = {w_Rdy1, w_Rdy0};
                    w_Prio    = w_Rdy0;
                    w_Next    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_To_Cnt = '0;
                w_Next   = S_WAIT;
            end
            S_WAIT: begin
                if (i_Tx_Done || w_To_Hit) begin
                    w_Gap_Cnt = '0;
                    w_Next    = S_GAP;
                end else begin
                    w_To_Cnt = r_To_Cnt + TW'(1);
                end
            end
            S_GAP: begin
                if (r_Gap_Cnt == GAP_LAST) begin
                    w_Grant = 2'b00;
                    w_Next  = S_IDLE;
                end else begin
                    w_Gap_Cnt = r_Gap_Cnt + GW'(1);
                end
            end
            default: begin
                w_Grant = 2'b00;
                w_Next  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State   <= S_IDLE;
            r_To_Cnt  <= '0;
            r_Gap_Cnt <= '0;
            r_Tx_Byte <= 8'h00;
            r_Grant   <= 2'b00;
            r_Prio    <= 1'b0;
        end else begin
            r_State   <= w_Next;
            r_To_Cnt  <= w_To_Cnt;
            r_Gap_Cnt <= w_Gap_Cnt;
            r_Tx_Byte <= w_Tx_Byte;
            r_Grant   <= w_Grant;
            r_Prio    <= w_Prio;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 1024, meaning clocks to wait for i_Tx_Done before aborting a byte; legal range 16..2047.
REQ-002 SHALL have parameter GAP_CLKS, default 4, meaning idle clocks after each byte before the next launch; legal range 1..15.
REQ-003 SHALL have port i_Clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_Req0_Valid  in  1  and i_Req0_Byte  in  8, requester 0 byte offer.
REQ-006 SHALL have port o_Req0_Ready  out  1  requester 0 byte accepted this cycle when Valid&Ready.
REQ-007 SHALL have ports i_Req1_Valid  in  1, i_Req1_Byte  in  8 and o_Req1_Ready  out  1, same meaning for requester 1.
REQ-008 SHALL have port o_Tx_DV  out  1  one-cycle launch strobe to the UART transmitter.
REQ-009 SHALL have port o_Tx_Byte  out  8  byte to the UART transmitter.
REQ-010 SHALL have ports i_Tx_Active  in  1 and i_Tx_Done  in  1, transmitter status and one-cycle completion pulse.
REQ-011 SHALL have port o_Grant  out  2  one-hot current owner (bit0=req0, bit1=req1); 00 when none.
REQ-012 SHALL have ports o_Busy  out  1 (state not IDLE) and o_Timeout  out  1 (one-cycle abort pulse).

Function
REQ-013 SHALL implement states IDLE, LAUNCH, WAIT, GAP.
REQ-014 IDLE: o_ReqN_Ready SHALL be combinational: high only for the arbitration winner, only in IDLE, only when that requester's Valid is high.
REQ-015 Arbitration SHALL be round-robin: if both Valid, the requester holding priority wins; if one Valid, it wins regardless of priority.
REQ-016 On acceptance (cycle t), SHALL register winner's byte into o_Tx_Byte, set o_Grant to winner, pass priority to the other requester, go to LAUNCH.
REQ-017 LAUNCH (cycle t+1): o_Tx_DV SHALL be high for exactly this cycle; next state WAIT with timeout counter cleared.
REQ-018 o_Tx_Byte SHALL hold stable from t+1 until return to IDLE; the transmitter samples it one cycle after the strobe.
REQ-019 WAIT: counter SHALL increment each cycle; on i_Tx_Done high, go to GAP.
REQ-020 WAIT: if counter reaches DONE_TIMEOUT-1 without i_Tx_Done, SHALL pulse o_Timeout one cycle and go to GAP.
REQ-021 i_Tx_Done and timeout in the same cycle: done SHALL win, no o_Timeout.
REQ-022 GAP: SHALL wait GAP_CLKS cycles, then clear o_Grant and enter IDLE; i_Tx_Done pulses outside WAIT are ignored.
REQ-023 i_Tx_Active SHALL NOT affect transitions; it only gates: IDLE SHALL not accept while i_Tx_Active is high.
REQ-024 Valid deasserted before acceptance SHALL cause no transfer; no byte is ever dropped or duplicated once accepted.
REQ-025 Minimum byte period SHALL be 1 (accept) + 1 (launch) + done latency + GAP_CLKS cycles.

Reset
REQ-026 On i_Reset high at a clock edge: state IDLE, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Grant=00, o_Busy=0, o_Timeout=0, counters 0, priority to requester 0.
REQ-027 Reset mid-byte SHALL abort the grant immediately; the aborted byte is not re-offered; Ready SHALL be low during reset.

Verification
REQ-028 Req0 Valid with 8'hA5, Req1 idle -> Ready0 one cycle, o_Tx_DV one cycle later with o_Tx_Byte=A5, o_Grant=01 until GAP ends.
REQ-029 Both Valid (0x11, 0x22) continuously after reset -> bytes launched in order 11,22,11,22; each DV preceded by matching Ready.
REQ-030 i_Tx_Done held low after launch -> o_Timeout pulses exactly 1024 cycles after DV (counter 0..1023), returns to IDLE after 4 GAP cycles.
REQ-031 i_Tx_Done asserted on the timeout cycle -> no o_Timeout, normal GAP.
REQ-032 i_Reset asserted in WAIT -> next cycle all outputs at reset values; a subsequent Req1 byte 0x5A is arbitrated with requester 0 priority.
REQ-033 With real uart_tx (87 clks/bit) attached -> serial line shows start, 8 LSB-first data bits, stop per byte, no overlap between frames.
